// File: rtl/mem_handshake_responder.sv
// Big-endian byte memory behind the CPU's multicycle mem_enable/moc handshake.
// Inserts WAIT_CYCLES wait states, then commits the access and raises moc.
// Ports: clk, reset (sync, active low), mem_enable, rw (1 = read), size,
//   address, data_in -> data_out, moc, addr_err (valid while moc = 1).
// Build option: define MEM_SUBWORD_EN to honour byte/halfword sizes;
//   otherwise every access is a full word.
module mem_handshake_responder #(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [3:0]  count;
    logic        accept;
    logic        commit;

    logic        rwL;
    logic [1:0]  sizeL;
    logic [31:0] addrL;
    logic [31:0] dataL;

    logic [7:0]  mem [DEPTH];

    logic          isWord;
    logic          isHalf;
    logic          misalign;
    logic          accErr;
    logic [AW-1:2] wIdx;
    logic [31:0]   rdWord;
    logic [31:0]   rdData;
    logic [3:0]    laneWe;
    logic [7:0]    laneByte [4];
    logic          memWe;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The counter is loaded on acceptance and the commit happens once it
    // has reached zero, so moc rises WAIT_CYCLES + 1 edges after acceptance.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_enable) begin
                    accept    = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    commit    = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (!mem_enable) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // ---------------- request latch ----------------
`ifdef MEM_SUBWORD_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            sizeL <= 2'b10;
        end else if (accept) begin
            sizeL <= size;
        end
    end
`else
    logic unusedSize;
    assign unusedSize = ^size;
    assign sizeL      = 2'b10;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            rwL      <= 1'b0;
            addrL    <= '0;
            dataL    <= '0;
            count    <= '0;
            moc      <= 1'b0;
            addr_err <= 1'b0;
            data_out <= '0;
        end else begin
            if (accept) begin
                rwL   <= rw;
                addrL <= address;
                dataL <= data_in;
                count <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (commit) begin
                moc      <= 1'b1;
                addr_err <= accErr;
                if (rwL) begin
                    data_out <= accErr ? 32'd0 : rdData;
                end
            end else if (state == DONE && !mem_enable) begin
                moc      <= 1'b0;
                addr_err <= 1'b0;
            end
        end
    end

    // ---------------- access decode ----------------
    // size 11 counts as a word because only bit 1 is tested.
    assign isWord = sizeL[1];
    assign isHalf = (sizeL == 2'b01);

    always_comb begin
        misalign = 1'b0;
        if (isWord) begin
            misalign = (addrL[1:0] != 2'b00);
        end else if (isHalf) begin
            misalign = addrL[0];
        end
    end

    assign accErr = (addrL >= 32'(DEPTH)) || misalign;
    assign wIdx   = addrL[AW-1:2];

    // Lowest address is the most significant byte.
    assign rdWord = {mem[{wIdx, 2'd0}], mem[{wIdx, 2'd1}],
                     mem[{wIdx, 2'd2}], mem[{wIdx, 2'd3}]};

    always_comb begin
        rdData = rdWord;
        if (!isWord) begin
            if (isHalf) begin
                rdData = {16'd0, addrL[1] ? rdWord[15:0] : rdWord[31:16]};
            end else begin
                unique case (addrL[1:0])
                    2'd0:    rdData = {24'd0, rdWord[31:24]};
                    2'd1:    rdData = {24'd0, rdWord[23:16]};
                    2'd2:    rdData = {24'd0, rdWord[15:8]};
                    default: rdData = {24'd0, rdWord[7:0]};
                endcase
            end
        end
    end

    // Lane data is laid out for every size at once; laneWe picks the lanes.
    always_comb begin
        laneWe = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            laneByte[i] = dataL[7:0];
        end
        if (isWord) begin
            laneWe      = 4'b1111;
            laneByte[0] = dataL[31:24];
            laneByte[1] = dataL[23:16];
            laneByte[2] = dataL[15:8];
            laneByte[3] = dataL[7:0];
        end else if (isHalf) begin
            laneByte[0] = dataL[15:8];
            laneByte[1] = dataL[7:0];
            laneByte[2] = dataL[15:8];
            laneByte[3] = dataL[7:0];
            laneWe      = addrL[1] ? 4'b1100 : 4'b0011;
        end else begin
            laneWe[addrL[1:0]] = 1'b1;
        end
    end

    // A reset landing on the commit edge suppresses the write.
    assign memWe = commit && !rwL && !accErr && reset;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (memWe && laneWe[i]) begin
                mem[{wIdx, 2'(i)}] <= laneByte[i];
            end
        end
    end

endmodule
